// File: rtl/sprite_addr_gen.sv
// Walks every pixel of a SPR_W x SPR_H sprite placed at (x, y), emitting framebuffer
// addresses and sprite-ROM indices over valid/ready, with right/bottom clipping and flips.
module sprite_addr_gen #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int SPR_W    = 8,
    parameter int SPR_H    = 8,
    parameter int ADDR_W   = 17,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int IDX_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic              flip_h,
    input  logic              flip_v,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [IDX_W-1:0]  spr_idx,
    output logic              busy,
    output logic              done
);

    localparam int CW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int XSW = X_W + 1;
    localparam int YSW = Y_W + 1;

    localparam logic [CW-1:0]     COL_LAST   = CW'(SPR_W - 1);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(SPR_H - 1);
    localparam logic [ADDR_W-1:0] SCREEN_W_A = ADDR_W'(SCREEN_W);
    localparam logic [XSW-1:0]    SCREEN_W_X = XSW'(SCREEN_W);
    localparam logic [YSW-1:0]    SCREEN_H_Y = YSW'(SCREEN_H);
    localparam logic [IDX_W-1:0]  SPR_W_I    = IDX_W'(SPR_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [X_W-1:0]    x_reg, x_next;
    logic [Y_W-1:0]    y_reg, y_next;
    logic              flip_h_reg, flip_h_next;
    logic              flip_v_reg, flip_v_next;
    logic [RW-1:0]     row_reg, row_next;
    logic [CW-1:0]     col_reg, col_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic              valid_reg, valid_next;
    logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
    logic [IDX_W-1:0]  spr_idx_reg, spr_idx_next;

    logic              retire;
    logic              last_pos;
    logic              in_bounds_next;
    logic [XSW-1:0]    x_sum;
    logic [YSW-1:0]    y_sum;
    logic [CW-1:0]     col_s;
    logic [RW-1:0]     row_s;

    assign last_pos = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
    // A clipped position retires unconditionally so it costs exactly one cycle.
    assign retire   = (state_reg == RUN) && (!valid_reg || addr_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            flip_h_reg   <= 1'b0;
            flip_v_reg   <= 1'b0;
            row_reg      <= '0;
            col_reg      <= '0;
            row_base_reg <= '0;
            valid_reg    <= 1'b0;
            fb_addr_reg  <= '0;
            spr_idx_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            flip_h_reg   <= flip_h_next;
            flip_v_reg   <= flip_v_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            row_base_reg <= row_base_next;
            valid_reg    <= valid_next;
            fb_addr_reg  <= fb_addr_next;
            spr_idx_reg  <= spr_idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (retire && last_pos) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Computes the next position and the registered outputs that describe it.
    always_comb begin
        x_next        = x_reg;
        y_next        = y_reg;
        flip_h_next   = flip_h_reg;
        flip_v_next   = flip_v_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        row_base_next = row_base_reg;

        if (state_reg == IDLE && start) begin
            x_next        = x;
            y_next        = y;
            flip_h_next   = flip_h;
            flip_v_next   = flip_v;
            row_next      = '0;
            col_next      = '0;
            row_base_next = ADDR_W'(y) * SCREEN_W_A + ADDR_W'(x);
        end else if (retire && !last_pos) begin
            if (col_reg == COL_LAST) begin
                col_next      = '0;
                row_next      = row_reg + RW'(1);
                row_base_next = row_base_reg + SCREEN_W_A;
            end else begin
                col_next = col_reg + CW'(1);
            end
        end

        x_sum          = XSW'(x_next) + XSW'(col_next);
        y_sum          = YSW'(y_next) + YSW'(row_next);
        in_bounds_next = (x_sum < SCREEN_W_X) && (y_sum < SCREEN_H_Y);

        col_s = flip_h_next ? (COL_LAST - col_next) : col_next;
        row_s = flip_v_next ? (ROW_LAST - row_next) : row_next;

        valid_next   = (state_next == RUN) && in_bounds_next;
        fb_addr_next = row_base_next + ADDR_W'(col_next);
        spr_idx_next = IDX_W'(row_s) * SPR_W_I + IDX_W'(col_s);
    end

    assign addr_valid = valid_reg;
    assign fb_addr    = fb_addr_reg;
    assign spr_idx    = spr_idx_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);

endmodule

// File: doc/sprite_addr_gen.md
Name: sprite_addr_gen

Overview:
Sequential, parametrised successor to the fixed 8x8 combinational sprite address calculator. On a start request it walks every pixel of a SPR_W x SPR_H sprite placed at (x, y) on a SCREEN_W x SCREEN_H framebuffer. For each pixel it emits a framebuffer address and a sprite-ROM index over a valid/ready handshake.
Adds clipping at the right and bottom screen edges and horizontal/vertical flip. Sits between the sprite engine control and the framebuffer write port.

Parameters:
SCREEN_W, 320, framebuffer width in pixels
SCREEN_H, 240, framebuffer height in pixels
SPR_W, 8, sprite width in pixels (>=1)
SPR_H, 8, sprite height in pixels (>=1)
ADDR_W, 17, framebuffer address width (must hold SCREEN_W*SCREEN_H-1)
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
IDX_W, 6, sprite index width (must hold SPR_W*SPR_H-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request to draw a sprite; sampled only in IDLE
x  in  X_W  sprite left column; latched on accepted start
y  in  Y_W  sprite top row; latched on accepted start
flip_h  in  1  mirror columns; latched on accepted start
flip_v  in  1  mirror rows; latched on accepted start
addr_valid  out  1  fb_addr/spr_idx hold a drawable pixel
addr_ready  in  1  consumer accepts the current pixel
fb_addr  out  ADDR_W  framebuffer address = (y+row)*SCREEN_W + x + col
spr_idx  out  IDX_W  sprite ROM index = row_s*SPR_W + col_s
busy  out  1  high in RUN and DONE states
done  out  1  one-cycle pulse after the last pixel position retires

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE; addr_valid=0, busy=0, done=0, fb_addr=0, spr_idx=0; row/col counters=0. Reset mid-RUN abandons the sprite with no done pulse.
- States:
  - IDLE: start=1 latches x, y, flip_h and flip_v, sets row=0, col=0, row_base=y*SCREEN_W+x, and moves to RUN. start=0 stays in IDLE.
  - RUN: exactly one pixel position (row, col) is current.
    - in_bounds = (x+col < SCREEN_W) && (y+row < SCREEN_H). Compute both sums one bit wider than X_W/Y_W so there is no wrap.
    - addr_valid = in_bounds.
    - Position retires when (in_bounds && addr_ready) or !in_bounds. A clipped position costs exactly one cycle with addr_valid=0.
    - On retire: col++. At col==SPR_W-1: col=0, row++, row_base += SCREEN_W.
    - Retiring (SPR_H-1, SPR_W-1) moves to DONE.
  - DONE: done=1 for one cycle, addr_valid=0, then IDLE.
- start is ignored in RUN and DONE. No queuing.
- Row base is maintained incrementally. No multiplier in the per-pixel path. The multiply on the start cycle may use a constant-multiply by SCREEN_W.
- fb_addr = row_base + col, truncated to ADDR_W. Only meaningful while addr_valid=1.
- Flip mapping:
  - col_s = flip_h ? SPR_W-1-col : col
  - row_s = flip_v ? SPR_H-1-row : row
- Outputs are registered and reflect the current position. While addr_valid=1 && addr_ready=0, fb_addr, spr_idx and addr_valid hold stable.
- Latency: start accepted at edge N; first position is current in cycle N+1. With addr_ready=1 and no clipping, the last pixel is in cycle N+SPR_W*SPR_H and done is in cycle N+SPR_W*SPR_H+1.
- Fully off-screen sprite (x>=SCREEN_W or y>=SCREEN_H): all positions clipped, zero valid beats, done after SPR_W*SPR_H RUN cycles.
- Left/top clipping is not supported: coordinates are unsigned.

Test Plan:
- Default params, x=0, y=0, addr_ready=1, no flip -> 64 beats; fb_addr 0..7, 320..327, ... 2240..2247; spr_idx 0..63 in order; done in cycle 65 after the start edge.
- x=100, y=50, addr_ready toggling 1,0,1,0 -> every beat's fb_addr/spr_idx held while ready=0; first addr 16100, last addr 18347; 64 accepted beats; done once.
- x=316, y=0 -> per row only cols 0..3 valid (addr 316..319, 636..639, ...); 32 valid beats; still 64 RUN cycles then done.
- x=0, y=236, flip_h=1 -> rows 0..3 valid only; first beat fb_addr 75520 with spr_idx 7; 32 beats. flip_v=1 on a full sprite -> first spr_idx 56.
- start pulsed again mid-RUN -> ignored, sprite completes unchanged. rst_n low mid-RUN -> addr_valid/busy drop immediately, no done; a new start afterwards runs cleanly from row 0.
